// File: rtl/dmem_busywait_ctrl.sv
// dmem_busywait_ctrl: data-memory responder for the MEM stage.
// It accepts a level-held load/store request and raises BUSYWAIT to stall
// every pipeline register for LATENCY cycles. It then returns the extended
// load data on READ_DATA, where it stays valid for the one DONE cycle in
// which the pipeline advances.
//
// Ports:
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   READ / WRITE      load / store request (WRITE wins if both are high)
//   FUNC3             RV32 load/store funct3
//   ADDRESS           byte address; the word index wraps modulo DEPTH_WORDS
//   WRITE_DATA        store data
//   READ_DATA         extended load result, held until the next load completes
//   BUSYWAIT          combinational stall
//   MISALIGNED        (only with DMEM_MISALIGN_FLAG_EN) one-cycle flag in DONE
//
// Optional feature macro: DMEM_MISALIGN_FLAG_EN. When it is defined, a
// misaligned halfword or word access is flagged and suppressed. When it is
// undefined, the low address bits are simply ignored.
module dmem_busywait_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
`ifdef DMEM_MISALIGN_FLAG_EN
    output logic        MISALIGNED,
`endif
    output logic        BUSYWAIT
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [2:0]         f3_q, f3_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               misal_flag_q, misal_flag_d;

    logic [31:0]        mem_q [DEPTH_WORDS];
    logic               mem_we;
    logic [31:0]        mem_wdata;

    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        mem_word;
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [31:0]        load_val;
    logic [31:0]        store_val;
    logic               store_ok;
    logic               misal;

    assign word_idx = addr_q[IDX_W+1:2];
    assign mem_word = mem_q[word_idx];
    assign sel_byte = mem_word[{addr_q[1:0], 3'b000} +: 8];
    assign sel_half = addr_q[1] ? mem_word[31:16] : mem_word[15:0];

`ifdef DMEM_MISALIGN_FLAG_EN
    assign misal = (((f3_q == 3'b001) || (f3_q == 3'b101)) && addr_q[0]) ||
                   ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
    assign MISALIGNED = misal_flag_q;
`else
    assign misal = 1'b0;
`endif

    // Extract the selected lane and extend it per funct3.
    always_comb begin
        load_val = 32'h0;
        case (f3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_val = mem_word;
            3'b100:  load_val = {24'h0, sel_byte};
            3'b101:  load_val = {16'h0, sel_half};
            default: load_val = 32'h0;
        endcase
    end

    // Merge the store data into the current word (read-modify-write).
    always_comb begin
        store_val = mem_word;
        store_ok  = 1'b1;
        case (f3_q)
            3'b000:  store_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001:  store_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            3'b010:  store_val = wdata_q;
            default: store_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        misal_flag_d = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = store_val;
        case (state_q)
            S_IDLE: begin
                if (READ || WRITE) begin
                    rd_d    = READ & ~WRITE;
                    wr_d    = WRITE;
                    f3_d    = FUNC3;
                    addr_d  = ADDRESS[IDX_W+1:0];
                    wdata_d = WRITE_DATA;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    misal_flag_d = misal;
                    if (!misal) begin
                        if (wr_q)      mem_we  = store_ok;
                        else if (rd_q) rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Always return to IDLE, so a request that is still held is not
            // accepted a second time in the same cycle it completes.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (RESET) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            rdata_d      = 32'h0;
            misal_flag_d = 1'b0;
            mem_we       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        rd_q         <= rd_d;
        wr_q         <= wr_d;
        f3_q         <= f3_d;
        addr_q       <= addr_d;
        wdata_q      <= wdata_d;
        rdata_q      <= rdata_d;
        misal_flag_q <= misal_flag_d;
    end

    // The storage array has no reset and keeps its contents across RESET.
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[word_idx] <= mem_wdata;
    end

    assign READ_DATA = rdata_q;
    assign BUSYWAIT  = ~RESET & (((state_q == S_IDLE) & (READ | WRITE)) |
                                 (state_q == S_BUSY));

endmodule

// File: tb/tb_dmem_busywait_ctrl.sv
module tb_dmem_busywait_ctrl;
    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        CLK = 1'b0;
    logic        RESET, READ, WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS, WRITE_DATA, READ_DATA;
    logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_FLAG_EN
    logic        MISALIGNED;
`endif

    int vectors = 0;
    int miscompares = 0;

    bit [31:0] mem_m [DEPTH];
    bit [31:0] rd_m;

    int        lat;
    bit [31:0] rdat;
    bit [31:0] rd_before;
    bit        to;

    always #5 CLK = ~CLK;

    dmem_busywait_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNC3(FUNC3),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
`ifdef DMEM_MISALIGN_FLAG_EN
        .MISALIGNED(MISALIGNED),
`endif
        .BUSYWAIT(BUSYWAIT)
    );

    // Reference model: byte-addressed memory computed with shifts and masks.
    function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] a);
        bit [31:0] w = mem_m[(a / 4) % DEPTH];
        bit [7:0]  b = 8'(w >> (8 * (a % 4)));
        bit [15:0] h = 16'(w >> (16 * ((a / 2) % 2)));
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd2:    return w;
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_store(bit [2:0] f3, bit [31:0] a, bit [31:0] d);
        int        idx = int'((a / 4) % DEPTH);
        int        bs  = 8 * int'(a % 4);
        int        hs  = 16 * int'((a / 2) % 2);
        bit [31:0] w   = mem_m[idx];
        case (f3)
            3'd0: mem_m[idx] = (w & ~(32'hFF << bs)) | ((d & 32'hFF) << bs);
            3'd1: mem_m[idx] = (w & ~(32'hFFFF << hs)) | ((d & 32'hFFFF) << hs);
            3'd2: mem_m[idx] = d;
            default: ;
        endcase
    endtask

    // Model of one transaction as seen by the pipeline.
    task automatic m_access(bit r, bit w, bit [2:0] f3, bit [31:0] a, bit [31:0] d);
        if (w)      m_store(f3, a, d);
        else if (r) rd_m = m_load(f3, a);
    endtask

    // Drives one request and measures the stall length. It returns READ_DATA
    // sampled in the first non-stalled cycle, and READ_DATA from the cycle before.
    task automatic do_access(input bit r, input bit w, input bit [2:0] f3,
                             input bit [31:0] a, input bit [31:0] d, input bit hold);
        @(posedge CLK); #1;
        READ = r; WRITE = w; FUNC3 = f3; ADDRESS = a; WRITE_DATA = d;
        lat = 0; to = 0; rd_before = READ_DATA;
        forever begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            rd_before = READ_DATA;
            lat++;
            if (lat > 50) begin to = 1; break; end
        end
        rdat = READ_DATA;
        if (!hold) begin
            @(posedge CLK); #1;
            READ = 0; WRITE = 0;
        end
    endtask

    task automatic test_reset;
        RESET = 1; READ = 1; WRITE = 0; FUNC3 = 3'd2; ADDRESS = 32'h0; WRITE_DATA = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b0) begin
            miscompares++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT);
        end
        @(posedge CLK); #1;
        READ = 0; RESET = 0;
        @(negedge CLK);
        vectors++;
        if (READ_DATA !== 32'h0 || BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got rd=%h bw=%b want 0/0", READ_DATA, BUSYWAIT);
        end
        rd_m = 0;
    endtask

    task automatic test_store_load;
        do_access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        m_access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        vectors++;
        if (to || lat != LAT) begin
            miscompares++; $display("FAIL sw_latency got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (rdat !== rd_m) begin
            miscompares++; $display("FAIL sw_rdata_hold got %h want %h", rdat, rd_m);
        end
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b0) begin
            miscompares++; $display("FAIL idle_after_done got %b want 0", BUSYWAIT);
        end
        do_access(1, 0, 3'd2, 32'h10, 32'h0, 0);
        vectors++;
        if (to || lat != LAT || rdat !== 32'hDEADBEEF || rd_before !== 32'h0) begin
            miscompares++;
            $display("FAIL lw_10 got lat=%0d rd=%h pre=%h want %0d/deadbeef/0",
                     lat, rdat, rd_before, LAT);
        end
        rd_m = 32'hDEADBEEF;
    endtask

    task automatic test_ext;
        bit [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        bit [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        bit [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            do_access(1, 0, f3s[i], as[i], 32'h0, 0);
            rd_m = exp[i];
            vectors++;
            if (to || rdat !== exp[i] || m_load(f3s[i], as[i]) !== exp[i]) begin
                miscompares++;
                $display("FAIL ext_%0d got %h want %h", i, rdat, exp[i]);
            end
        end
    endtask

    task automatic test_sub_word;
        do_access(0, 1, 3'd0, 32'h11, 32'h0000007F, 0);
        m_access(0, 1, 3'd0, 32'h11, 32'h7F);
        do_access(1, 0, 3'd2, 32'h10, 32'h0, 0);
        rd_m = 32'hDEAD7FEF;
        vectors++;
        if (to || rdat !== 32'hDEAD7FEF) begin
            miscompares++; $display("FAIL sb_11 got %h want dead7fef", rdat);
        end
        do_access(0, 1, 3'd1, 32'h12, 32'h00001234, 0);
        m_access(0, 1, 3'd1, 32'h12, 32'h1234);
        vectors++;
        if (rdat !== 32'hDEAD7FEF) begin
            miscompares++; $display("FAIL sh_rdata_hold got %h want dead7fef", rdat);
        end
        do_access(1, 0, 3'd2, 32'h10, 32'h0, 0);
        rd_m = 32'h12347FEF;
        vectors++;
        if (to || rdat !== 32'h12347FEF) begin
            miscompares++; $display("FAIL sh_12 got %h want 12347fef", rdat);
        end
    endtask

    task automatic test_back_to_back;
        int lat2;
        do_access(1, 0, 3'd2, 32'h10, 32'h0, 1);
        rd_m = m_load(3'd2, 32'h10);
        vectors++;
        if (to || lat != LAT || rdat !== rd_m) begin
            miscompares++;
            $display("FAIL held_first got lat=%0d rd=%h want %0d/%h", lat, rdat, LAT, rd_m);
        end
        // READ is still held: the DONE cycle must not be followed by a second
        // accept until the next cycle.
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b1) begin
            miscompares++; $display("FAIL held_reaccept got %b want 1", BUSYWAIT);
        end
        lat2 = 1;
        forever begin
            @(negedge CLK);
            if (!BUSYWAIT || lat2 > 50) break;
            lat2++;
        end
        vectors++;
        if (lat2 != LAT) begin
            miscompares++; $display("FAIL held_second_latency got %0d want %0d", lat2, LAT);
        end
        @(posedge CLK); #1;
        READ = 0;
    endtask

    task automatic test_reset_abort;
        do_access(0, 1, 3'd2, 32'h20, 32'hAAAA5555, 0);
        m_access(0, 1, 3'd2, 32'h20, 32'hAAAA5555);
        @(posedge CLK); #1;
        WRITE = 1; READ = 0; FUNC3 = 3'd2; ADDRESS = 32'h20; WRITE_DATA = 32'h12345678;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1;
        @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b0) begin
            miscompares++; $display("FAIL abort_bw_in_reset got %b want 0", BUSYWAIT);
        end
        @(posedge CLK); #1;
        RESET = 0; WRITE = 0;
        @(negedge CLK);
        rd_m = 0;
        vectors++;
        if (BUSYWAIT !== 1'b0 || READ_DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_state got bw=%b rd=%h want 0/0", BUSYWAIT, READ_DATA);
        end
        do_access(1, 0, 3'd2, 32'h20, 32'h0, 0);
        rd_m = 32'hAAAA5555;
        vectors++;
        if (to || rdat !== 32'hAAAA5555) begin
            miscompares++; $display("FAIL abort_no_write got %h want aaaa5555", rdat);
        end
    endtask

    task automatic test_both_wrap;
        bit [31:0] prev = rd_m;
        do_access(1, 1, 3'd2, 32'h40, 32'h1, 0);
        m_access(1, 1, 3'd2, 32'h40, 32'h1);
        vectors++;
        if (to || lat != LAT || rdat !== prev) begin
            miscompares++;
            $display("FAIL both_rdata got lat=%0d rd=%h want %0d/%h", lat, rdat, LAT, prev);
        end
        do_access(1, 0, 3'd2, 32'h40 + 4 * DEPTH, 32'h0, 0);
        rd_m = 32'h1;
        vectors++;
        if (to || rdat !== 32'h1) begin
            miscompares++; $display("FAIL wrap_lw got %h want 00000001", rdat);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            bit [31:0] d = $urandom;
            do_access(0, 1, 3'd2, 32'(i * 4), d, 0);
            m_access(0, 1, 3'd2, 32'(i * 4), d);
        end
        for (int i = 0; i < 40; i++) begin
            int        op = $urandom_range(0, 2);
            bit        r  = (op != 1);
            bit        w  = (op != 0);
            bit [2:0]  f3 = 3'($urandom_range(0, 7));
            bit [31:0] a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            bit [31:0] d  = $urandom;
            do_access(r, w, f3, a, d, 0);
            m_access(r, w, f3, a, d);
            vectors++;
            if (to || lat != LAT || rdat !== rd_m) begin
                miscompares++;
                $display("FAIL rand_%0d op=%0d f3=%0d a=%h got lat=%0d rd=%h want %0d/%h",
                         i, op, f3, a, lat, rdat, LAT, rd_m);
            end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_ext;
        test_sub_word;
        test_back_to_back;
        test_reset_abort;
        test_both_wrap;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
